// File: rtl/button_conditioner_pkg.sv
// Shared stopwatch constants: button channel indices, system clock rate and
// the default debounce / long-press timings derived from it.
package stopwatch_pkg;

    // Channel index of each front-panel button on the btn_n_* buses.
    typedef enum int unsigned {
        BTN_INICIAR = 0,
        BTN_RESET   = 1,
        BTN_CONTAR  = 2,
        BTN_PAUSAR  = 3,
        BTN_PARAR   = 4
    } btn_idx_e;

    localparam int CLK_HZ        = 50_000_000;
    localparam int N_BTN_DEFAULT = 5;

    // Converts a duration in milliseconds into clk cycles.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    // 10 ms debounce window and 1 s long-press hold.
    localparam int DB_CYCLES_DEFAULT   = ms_to_cycles(10);
    localparam int LONG_CYCLES_DEFAULT = ms_to_cycles(1000);

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus between the raw pins / consumer logic and the conditioner.
// master: drives raw pins, consumes conditioned outputs.
// slave : the conditioner itself.
interface button_conditioner_if #(
    parameter int N_BTN = 5
) ();
    logic [N_BTN-1:0] btn_n_raw;
    logic [N_BTN-1:0] btn_n_clean;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;

    modport master (
        output btn_n_raw,
        input  btn_n_clean,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_n_raw,
        output btn_n_clean,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/button_conditioner_debounce_ch.sv
// Single button channel: synchroniser, debounce counter, press/release pulses
// and, when BUTTON_CONDITIONER_LONG_PRESS_EN is defined, a long-press pulse.
module btn_debounce_ch
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int LONG_CYCLES = LONG_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n_raw,
    output logic o_btn_n_clean,
    output logic o_btn_press,
    output logic o_btn_release,
    output logic o_btn_long
);
    localparam int              DB_W    = $clog2(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_W-1:0]        r_db_cnt;
    logic                   r_stable;
    logic                   r_press;
    logic                   r_release;
    logic                   w_sample;
    logic                   w_differs;
    logic                   w_accept;

    assign w_sample  = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_sample != r_stable);
    // Terminal count reached with the sample still disagreeing: take the new level.
    assign w_accept  = w_differs && (r_db_cnt == DB_LAST);

    // Shift the asynchronous pin through the synchroniser chain (idle = released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '1;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_n_raw};
    end

    // Count consecutive disagreeing samples; flip the level and pulse at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable  <= 1'b1;
            r_db_cnt  <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_accept &&  r_stable;
            r_release <= w_accept && !r_stable;
            if (!w_differs || w_accept) r_db_cnt <= '0;
            else                        r_db_cnt <= r_db_cnt + 1'b1;
            if (w_accept) r_stable <= w_sample;
        end
    end

    assign o_btn_n_clean = r_stable;
    assign o_btn_press   = r_press;
    assign o_btn_release = r_release;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam int                HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_long;

    // Saturating hold timer while the clean level is pressed; one pulse per hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_long     <= 1'b0;
        end else if (r_stable) begin
            r_hold_cnt <= '0;
            r_long     <= 1'b0;
        end else begin
            r_long <= (r_hold_cnt == HOLD_PRE);
            if (r_hold_cnt != HOLD_LAST) r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    assign o_btn_long = r_long;
`else
    assign o_btn_long = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Top of the button front end: N_BTN independent conditioning channels.
// Optional long-press pulses are built when BUTTON_CONDITIONER_LONG_PRESS_EN
// is defined; otherwise btn_long is tied low.
module button_conditioner
    import stopwatch_pkg::*;
#(
    parameter int N_BTN       = N_BTN_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int LONG_CYCLES = LONG_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_conditioner_if.slave  bus
);
    logic [N_BTN-1:0] w_clean;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_release;
    logic [N_BTN-1:0] w_long;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_btn_n_raw   (bus.btn_n_raw[gi]),
            .o_btn_n_clean (w_clean[gi]),
            .o_btn_press   (w_press[gi]),
            .o_btn_release (w_release[gi]),
            .o_btn_long    (w_long[gi])
        );
    end

    assign bus.btn_n_clean = w_clean;
    assign bus.btn_press   = w_press;
    assign bus.btn_release = w_release;
    assign bus.btn_long    = w_long;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DB_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=20.
module tb_button_conditioner;
    import stopwatch_pkg::*;

    localparam int N    = 5;
    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int HL   = SYNC + DB;
    localparam int LAT  = SYNC + DB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    button_conditioner_if #(.N_BTN(N)) bus_if ();

    button_conditioner #(
        .N_BTN(N), .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .LONG_CYCLES(LONG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model: raw pin history per edge; a level is accepted when the
    // last DB synchronised samples (raw delayed by SYNC edges) all oppose it.
    bit [HL-1:0] m_hist   [N];
    bit          m_stable [N];
    bit          m_press  [N];
    bit          m_rel    [N];
    bit          m_long   [N];
    int          m_age    [N];

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_hist[c]   = '1;
            m_stable[c] = 1'b1;
            m_press[c]  = 1'b0;
            m_rel[c]    = 1'b0;
            m_long[c]   = 1'b0;
            m_age[c]    = 0;
        end
    endfunction

    function automatic void model_step(input logic [N-1:0] raw);
        bit [DB-1:0] win;
        bit [DB-1:0] want;
        for (int c = 0; c < N; c++) begin
            m_hist[c] = {m_hist[c][HL-2:0], raw[c]};
            win  = m_hist[c][HL-1:SYNC];
            want = {DB{~m_stable[c]}};
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            m_long[c]  = 1'b0;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
            if (!m_stable[c] && m_age[c] < LONG) begin
                m_age[c]++;
                if (m_age[c] == LONG) m_long[c] = 1'b1;
            end
`endif
            if (win == want) begin
                m_press[c]  = m_stable[c];
                m_rel[c]    = ~m_stable[c];
                m_stable[c] = ~m_stable[c];
                m_age[c]    = 0;
            end
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step(bus_if.btn_n_raw);
        end
    end

    task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle scoreboard: every output bus against the model, away from the edge.
    initial begin
        logic [N-1:0] e_clean, e_press, e_rel, e_long;
        forever begin
            @(negedge clk);
            #1;
            for (int c = 0; c < N; c++) begin
                e_clean[c] = m_stable[c];
                e_press[c] = m_press[c];
                e_rel[c]   = m_rel[c];
                e_long[c]  = m_long[c];
            end
            check_vec("sb_clean",   bus_if.btn_n_clean, e_clean);
            check_vec("sb_press",   bus_if.btn_press,   e_press);
            check_vec("sb_release", bus_if.btn_release, e_rel);
            check_vec("sb_long",    bus_if.btn_long,    e_long);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    // Edges until a press (rel=0) or release (rel=1) pulse on channel ch; -1 on timeout.
    task automatic wait_pulse(input int ch, input bit rel, input int max_cyc, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            tick(1);
            if ((rel ? bus_if.btn_release[ch] : bus_if.btn_press[ch]) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic [N-1:0] raw;
        int           hold;
        logic [N-1:0] exp_clean;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           cnt;
        int           first;
        int           rem[N];
        logic [N-1:0] r;

        vecs[0] = '{raw: 5'b11011, hold: 6,  exp_clean: 5'b11011};
        vecs[1] = '{raw: 5'b11111, hold: 6,  exp_clean: 5'b11111};
        vecs[2] = '{raw: 5'b11011, hold: 2,  exp_clean: 5'b11111};
        vecs[3] = '{raw: 5'b11111, hold: 8,  exp_clean: 5'b11111};
        vecs[4] = '{raw: 5'b01110, hold: 6,  exp_clean: 5'b01110};
        vecs[5] = '{raw: 5'b11111, hold: 6,  exp_clean: 5'b11111};
        vecs[6] = '{raw: 5'b10101, hold: 10, exp_clean: 5'b10101};
        vecs[7] = '{raw: 5'b11111, hold: 10, exp_clean: 5'b11111};

        // Reset held with every button pressed.
        bus_if.btn_n_raw = 5'b00000;
        rst_n = 1'b0;
        tick(3);
        check_vec("rst_clean", bus_if.btn_n_clean, 5'b11111);
        check_vec("rst_press", bus_if.btn_press, 5'b00000);
        check_vec("rst_rel",   bus_if.btn_release, 5'b00000);
        check_vec("rst_long",  bus_if.btn_long, 5'b00000);
        $display("[TB] reset held: clean=%b", bus_if.btn_n_clean);
        bus_if.btn_n_raw = 5'b11111;
        tick(1);
        rst_n = 1'b1;
        tick(8);

        // Table-driven level checks.
        for (int v = 0; v < 8; v++) begin
            bus_if.btn_n_raw = vecs[v].raw;
            tick(vecs[v].hold);
            check_vec($sformatf("vec%0d_clean", v), bus_if.btn_n_clean, vecs[v].exp_clean);
            $display("[TB] vec %0d raw=%b hold=%0d clean=%b", v, vecs[v].raw, vecs[v].hold, bus_if.btn_n_clean);
        end

        // Clean press / release latency on Contar.
        bus_if.btn_n_raw[BTN_CONTAR] = 1'b0;
        wait_pulse(BTN_CONTAR, 1'b0, 20, lat);
        check_int("contar_press_lat", lat, LAT);
        tick(1);
        check_int("contar_press_1cyc", int'(bus_if.btn_press[BTN_CONTAR]), 0);
        check_int("contar_clean_low", int'(bus_if.btn_n_clean[BTN_CONTAR]), 0);
        bus_if.btn_n_raw[BTN_CONTAR] = 1'b1;
        wait_pulse(BTN_CONTAR, 1'b1, 20, lat);
        check_int("contar_rel_lat", lat, LAT);
        tick(1);
        check_int("contar_rel_1cyc", int'(bus_if.btn_release[BTN_CONTAR]), 0);
        $display("[TB] contar press/release latency checked");
        tick(4);

        // Bouncing Reset button: toggles every 2 cycles, then settles pressed.
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            bus_if.btn_n_raw[BTN_RESET] = ~bus_if.btn_n_raw[BTN_RESET];
            for (int k = 0; k < 2; k++) begin
                tick(1);
                cnt += int'(bus_if.btn_press[BTN_RESET]) + int'(bus_if.btn_release[BTN_RESET]);
            end
        end
        check_int("bounce_no_pulse", cnt, 0);
        bus_if.btn_n_raw[BTN_RESET] = 1'b0;
        wait_pulse(BTN_RESET, 1'b0, 20, lat);
        check_int("bounce_settle_lat", lat, LAT);
        $display("[TB] bounce rejected, settled press latency=%0d", lat);
        bus_if.btn_n_raw = 5'b11111;
        tick(10);

        // Iniciar and Parar fall together.
        bus_if.btn_n_raw = 5'b01110;
        wait_pulse(BTN_INICIAR, 1'b0, 20, lat);
        check_int("dual_lat", lat, LAT);
        check_vec("dual_press", bus_if.btn_press, 5'b10001);
        check_vec("dual_clean", bus_if.btn_n_clean, 5'b01110);
        $display("[TB] simultaneous press: press=%b", bus_if.btn_press);
        bus_if.btn_n_raw = 5'b11111;
        tick(10);

        // Reset mid-debounce with Pausar held through it.
        bus_if.btn_n_raw[BTN_PAUSAR] = 1'b0;
        tick(SYNC + 3);
        rst_n = 1'b0;
        #1;
        check_vec("midrst_clean", bus_if.btn_n_clean, 5'b11111);
        check_vec("midrst_press", bus_if.btn_press, 5'b00000);
        tick(2);
        rst_n = 1'b1;
        wait_pulse(BTN_PAUSAR, 1'b0, 20, lat);
        check_int("midrst_press_lat", lat, LAT);
        $display("[TB] press after reset release latency=%0d", lat);
        bus_if.btn_n_raw = 5'b11111;
        tick(10);

        // Long hold on Contar.
        bus_if.btn_n_raw[BTN_CONTAR] = 1'b0;
        wait_pulse(BTN_CONTAR, 1'b0, 20, lat);
        check_int("long_press_lat", lat, LAT);
        cnt = 0;
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (bus_if.btn_long[BTN_CONTAR] === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
        check_int("long_delay", first, LONG);
        check_int("long_count", cnt, 1);
`else
        check_int("long_count_off", cnt, 0);
`endif
        $display("[TB] long hold: pulses=%0d first=%0d", cnt, first);
        bus_if.btn_n_raw = 5'b11111;
        tick(10);

        // Random bouncing on all channels, checked by the scoreboard.
        for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 8);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            r = bus_if.btn_n_raw;
            for (int c = 0; c < N; c++) begin
                rem[c]--;
                if (rem[c] == 0) begin
                    r[c] = ~r[c];
                    rem[c] = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 35) : $urandom_range(1, 8);
                end
            end
            bus_if.btn_n_raw = r;
            if (cyc == 750) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            tick(1);
        end
        $display("[TB] random phase done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
